// File: rtl/sync_deser_pkg.sv
// Shared types and default parameters for the sync-strobed serial deserializer.
package sync_deser_pkg;

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_PERIOD     = 3;
   localparam int unsigned DEF_LOCK_COUNT = 4;

   localparam int unsigned GAP_W = 3;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/sync_gap_monitor.sv
// Saturating gap counter between sync strobes; classifies each cycle as good, bad or timeout.
module sync_gap_monitor
   import sync_deser_pkg::*;
#(
   parameter int unsigned PERIOD = DEF_PERIOD
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_in,
   output logic good,
   output logic bad,
   output logic timeout
);

   localparam logic [GAP_W-1:0] GAP_MAX = '1;
   localparam logic [GAP_W-1:0] GAP_PER = GAP_W'(PERIOD);

   logic [GAP_W-1:0] gap_q, gap_d;

   always_comb begin
      gap_d = gap_q;
      if (sync_in) begin
         gap_d = GAP_W'(1);
      end else if (gap_q != GAP_MAX) begin
         gap_d = gap_q + GAP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end

   // A saturated gap never equals PERIOD, so a late sync falls into bad.
   assign good    = sync_in  && (gap_q == GAP_PER);
   assign bad     = sync_in  && (gap_q != GAP_PER);
   assign timeout = !sync_in && (gap_q == GAP_PER);

endmodule

// File: rtl/sync_deser.sv
// Locks onto an evenly spaced sync strobe, assembles LSB-first words and hands them out over valid/ready.
module sync_deser
   import sync_deser_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned PERIOD     = DEF_PERIOD,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             q_in,
   input  logic             sync_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             locked,
   output logic             sync_err,
   output logic             overrun
);

   localparam int unsigned BIT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             sync_err_q, sync_err_d;
   logic             overrun_q, overrun_d;

   logic             good, bad, timeout;
   logic             complete;
   logic [WIDTH-1:0] shifted;

   sync_gap_monitor #(
      .PERIOD (PERIOD)
   ) u_gap (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_in (sync_in),
      .good    (good),
      .bad     (bad),
      .timeout (timeout)
   );

   // New bit enters at the MSB so the first bit ends up in the LSB after WIDTH shifts.
   assign shifted = {q_in, shift_q[WIDTH-1:1]};

   always_comb begin
      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      sync_err_d   = 1'b0;
      overrun_d    = 1'b0;
      complete     = 1'b0;

      case (state_q)
         HUNT: begin
            if (sync_in) begin
               state_d    = VERIFY;
               good_cnt_d = CNT_W'(1);
            end
         end
         VERIFY: begin
            if (good) begin
               if (good_cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
                  state_d    = LOCKED;
                  good_cnt_d = '0;
                  bit_cnt_d  = '0;
                  shift_d    = '0;
               end else begin
                  good_cnt_d = good_cnt_q + CNT_W'(1);
               end
            end else if (bad) begin
               good_cnt_d = CNT_W'(1);
            end else if (timeout) begin
               state_d    = HUNT;
               good_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (good) begin
               shift_d = shifted;
               if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  complete  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else if (bad || timeout) begin
               sync_err_d = 1'b1;
               bit_cnt_d  = '0;
               shift_d    = '0;
               state_d    = HUNT;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase

      // Output handshake: a load in the consume cycle keeps valid high with the new word.
      if (word_valid_q && out_ready) begin
         word_valid_d = 1'b0;
      end
      if (complete) begin
         if (!word_valid_q || out_ready) begin
            word_d       = shifted;
            word_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= HUNT;
         good_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         sync_err_q   <= sync_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign sync_err   = sync_err_q;
   assign overrun    = overrun_q;
   assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_sync_deser.sv
// Randomized scoreboard bench for sync_deser against a sync-event level reference model.
module tb_sync_deser;

   localparam int W  = 8;
   localparam int P  = 3;
   localparam int LC = 4;

   localparam int M_HUNT = 0;
   localparam int M_VER  = 1;
   localparam int M_LOCK = 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         q_in;
   logic         sync_in;
   logic         out_ready;
   logic [W-1:0] word;
   logic         word_valid;
   logic         locked;
   logic         sync_err;
   logic         overrun;

   always #5 clk = ~clk;

   sync_deser #(
      .WIDTH      (W),
      .PERIOD     (P),
      .LOCK_COUNT (LC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .q_in       (q_in),
      .sync_in    (sync_in),
      .out_ready  (out_ready),
      .word       (word),
      .word_valid (word_valid),
      .locked     (locked),
      .sync_err   (sync_err),
      .overrun    (overrun)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state
   int           mode;
   int           good_run;
   int           since;
   bit           bits[$];
   bit           exp_valid;
   bit           exp_locked;
   int           ready_pct;
   bit           alt;
   logic [W-1:0] exp_words[$];
   int           err_q[$];
   int           ovr_q[$];

   // Monitor history
   bit           prev_hold;
   logic [W-1:0] prev_word;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      mode       = M_HUNT;
      good_run   = 0;
      since      = 0;
      bits.delete();
      exp_valid  = 1'b0;
      exp_locked = 1'b0;
      exp_words.delete();
      err_q.delete();
      ovr_q.delete();
   endtask

   // One clock cycle: drive inputs, predict effects of the coming edge, commit after the edge.
   task automatic step(input bit s, input bit q);
      bit           rdy, good, bad, tmo, done, nv;
      int           e;
      logic [W-1:0] w;
      rdy       = ($urandom_range(99) < ready_pct);
      sync_in   = s;
      q_in      = q;
      out_ready = rdy;
      e         = cyc + 1;
      good      = s && (since == P);
      bad       = s && !good;
      tmo       = !s && (since == P);
      done      = 1'b0;
      w         = '0;
      case (mode)
         M_HUNT: if (s) begin
            mode     = M_VER;
            good_run = 1;
         end
         M_VER: begin
            if (good) begin
               good_run++;
               if (good_run == LC) begin
                  mode = M_LOCK;
                  bits.delete();
               end
            end else if (bad) begin
               good_run = 1;
            end else if (tmo) begin
               mode     = M_HUNT;
               good_run = 0;
            end
         end
         default: begin
            if (good) begin
               bits.push_back(q);
               if (bits.size() == W) begin
                  done = 1'b1;
                  foreach (bits[i]) w[i] = bits[i];
                  bits.delete();
               end
            end else if (bad || tmo) begin
               err_q.push_back(e);
               bits.delete();
               mode = M_HUNT;
            end
         end
      endcase
      since = s ? 1 : since + 1;
      nv = (exp_valid && rdy) ? 1'b0 : exp_valid;
      if (done) begin
         if (!exp_valid || rdy) begin
            exp_words.push_back(w);
            nv = 1'b1;
         end else begin
            ovr_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      exp_valid  = nv;
      exp_locked = (mode == M_LOCK);
      cyc++;
   endtask

   task automatic sync_at(input int gap, input bit q);
      for (int i = 1; i < gap; i++) step(1'b0, 1'($urandom_range(1)));
      step(1'b1, q);
   endtask

   task automatic alt_sync(input int gap);
      sync_at(gap, alt);
      alt = ~alt;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sync_in = 1'b0;
      #2;
      check("rst_word", word, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_sync_err", sync_err, 0);
      check("rst_overrun", overrun, 0);
      reset_n = 1'b1;
      model_reset();
      prev_hold = 1'b0;
   endtask

   // Monitor: compares every presented output against the scoreboard queues.
   always @(negedge clk) begin
      bit hit;
      if (reset_n === 1'b1) begin
         check("locked", locked, exp_locked);
         check("word_valid", word_valid, exp_valid);
         hit = (err_q.size() > 0) && (err_q[0] == cyc);
         if (hit) void'(err_q.pop_front());
         check("sync_err", sync_err, hit);
         hit = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
         if (hit) void'(ovr_q.pop_front());
         check("overrun", overrun, hit);
         if (word_valid && prev_hold) check("word_hold", word, prev_word);
         if (word_valid && out_ready) begin
            if (exp_words.size() == 0) check("word_unexpected", 1, 0);
            else check("word", word, exp_words.pop_front());
         end
         prev_hold = word_valid && !out_ready;
         prev_word = word;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g[7];
      reset_n   = 1'b1;
      sync_in   = 1'b0;
      q_in      = 1'b0;
      out_ready = 1'b0;
      ready_pct = 100;
      prev_hold = 1'b0;
      model_reset();
      #1;
      do_reset();

      // Alternating 1,0,... at the nominal period, consumer always ready
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      alt = 1'b1;
      for (int i = 0; i < 40; i++) alt_sync(P);

      // Consumer stalls for 60 cycles, then resumes
      ready_pct = 0;
      for (int i = 0; i < 20; i++) alt_sync(P);
      ready_pct = 100;
      for (int i = 0; i < 10; i++) alt_sync(P);

      // One sync arrives late while locked, then relock
      alt_sync(4);
      for (int i = 0; i < 14; i++) alt_sync(P);

      // Stream stops while locked
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

      // Bad spacing during verification delays lock
      g = '{5, 3, 3, 2, 3, 3, 3};
      foreach (g[i]) alt_sync(g[i]);
      for (int i = 0; i < 5; i++) alt_sync(P);

      // Reset mid-word, then fresh assembly
      do_reset();
      for (int i = 0; i < 20; i++) alt_sync(P);

      // Randomized spacing, data and back-pressure
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(49) == 0) ready_pct = $urandom_range(100);
         if ($urandom_range(399) == 0) do_reset();
         if ($urandom_range(11) == 0) sync_at($urandom_range(7, 1), 1'($urandom_range(1)));
         else sync_at(P, 1'($urandom_range(1)));
      end

      // Drain any pending word
      ready_pct = 100;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      check("words_left", exp_words.size(), 0);
      check("sync_err_left", err_q.size(), 0);
      check("overrun_left", ovr_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
